// File: rtl/eth_fifo_frame_reader.sv
// Read-side sequencer for the Ethernet TX prefetch FIFO: pops a length header,
// streams payload words to the MAC with sof/eof/keep, drains bad frames, enforces IFG.
module eth_fifo_frame_reader #(
    parameter int C_DATA_W  = 32,
    parameter int C_MIN_LEN = 60,
    parameter int C_MAX_LEN = 1514,
    parameter int C_IFG     = 12
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                enable,
    input  logic [C_DATA_W-1:0] fifo_rd_data,
    input  logic                fifo_rd_vld,
    output logic                fifo_rd_en,
    output logic [C_DATA_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_sof,
    output logic                m_eof,
    output logic [3:0]          m_keep,
    output logic                busy,
    output logic                err_len,
    output logic [15:0]         frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DRAIN,
        GAP
    } state_t;

    localparam logic [15:0] MIN_LEN  = 16'(C_MIN_LEN);
    localparam logic [15:0] MAX_LEN  = 16'(C_MAX_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(C_IFG - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  len_lsb;
    logic [16:0] remaining;
    logic [7:0]  gap_cnt;
    logic        first_word;

    logic [15:0] hdr_len;
    logic [16:0] hdr_words;
    logic        hdr_ok;
    logic        pop;
    logic        beat_accept;
    logic [3:0]  keep_last;

    // Header decode is 17-bit so a 0xFFFF length rounds up without overflow.
    assign hdr_len     = fifo_rd_data[15:0];
    assign hdr_words   = ({1'b0, hdr_len} + 17'd3) >> 2;
    assign hdr_ok      = (hdr_len >= MIN_LEN) && (hdr_len <= MAX_LEN);
    assign pop         = fifo_rd_en & fifo_rd_vld;
    assign beat_accept = m_valid & m_ready;
    assign busy        = (state != IDLE);

    always_comb begin
        case (len_lsb)
            2'd0:    keep_last = 4'hF;
            2'd1:    keep_last = 4'h1;
            2'd2:    keep_last = 4'h3;
            default: keep_last = 4'h7;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The output register can refill in the same cycle a beat leaves, which
    // keeps full throughput without a skid buffer.
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                fifo_rd_en = 1'b1;
                if (fifo_rd_vld) begin
                    if (hdr_ok) begin
                        state_nxt = PAYLOAD;
                    end else if (hdr_words != 17'd0) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = GAP;
                    end
                end
            end
            PAYLOAD: begin
                fifo_rd_en = (remaining != 17'd0) & (~m_valid | m_ready);
                if (beat_accept && m_eof) begin
                    state_nxt = GAP;
                end
            end
            DRAIN: begin
                fifo_rd_en = (remaining != 17'd0);
                if (fifo_rd_vld && (remaining == 17'd1)) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == IFG_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            len_lsb    <= 2'd0;
            remaining  <= 17'd0;
            gap_cnt    <= 8'd0;
            first_word <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            m_eof      <= 1'b0;
            m_keep     <= 4'h0;
            err_len    <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            err_len <= 1'b0;
            case (state)
                IDLE: begin
                    gap_cnt <= 8'd0;
                end
                HDR: begin
                    if (pop) begin
                        len_lsb    <= hdr_len[1:0];
                        remaining  <= hdr_words;
                        first_word <= 1'b1;
                        err_len    <= ~hdr_ok;
                    end
                end
                PAYLOAD: begin
                    if (pop) begin
                        m_data     <= fifo_rd_data;
                        m_valid    <= 1'b1;
                        m_sof      <= first_word;
                        first_word <= 1'b0;
                        m_eof      <= (remaining == 17'd1);
                        m_keep     <= (remaining == 17'd1) ? keep_last : 4'hF;
                        remaining  <= remaining - 17'd1;
                    end else if (beat_accept) begin
                        m_valid <= 1'b0;
                        m_sof   <= 1'b0;
                        m_eof   <= 1'b0;
                        m_keep  <= 4'h0;
                    end
                    if (beat_accept && m_eof) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        remaining <= remaining - 17'd1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_fifo_frame_reader.sv
// Randomized bench for eth_fifo_frame_reader: a queue-based FIFO model feeds frames,
// and a beat scoreboard built from frame lengths checks the MAC-side stream.
module tb_eth_fifo_frame_reader;

    localparam int C_IFG   = 12;
    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        enable;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_vld;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eof;
    logic [3:0]  m_keep;
    logic        busy;
    logic        err_len;
    logic [15:0] frame_cnt;

    always #5 rd_clk = ~rd_clk;

    eth_fifo_frame_reader #(
        .C_DATA_W (32),
        .C_MIN_LEN(MIN_LEN),
        .C_MAX_LEN(MAX_LEN),
        .C_IFG    (C_IFG)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .enable      (enable),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_vld (fifo_rd_vld),
        .fifo_rd_en  (fifo_rd_en),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eof       (m_eof),
        .m_keep      (m_keep),
        .busy        (busy),
        .err_len     (err_len),
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        logic [31:0] w;
        bit          is_hdr;
        bit          bad;
        bit          end_on_pop;
    } fent_t;

    typedef struct {
        logic [31:0] d;
        bit          sof;
        bit          eof;
        logic [3:0]  keep;
        int          idx;
    } beat_t;

    fent_t fifo_q[$];
    beat_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;
    bit exp_err     = 1'b0;
    int edge_no     = 0;
    int last_end_edge = 0;
    bit end_valid   = 1'b0;
    bit gap_chk     = 1'b0;
    bit tput_chk    = 1'b0;
    int sof_edge    = 0;
    int vld_pct     = 100;
    int rdy_pct     = 100;
    bit held        = 1'b0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // Pushes header + payload words into the FIFO model and, for legal lengths,
    // the beats the MAC side must see.
    task automatic add_frame(input int len);
        fent_t       e;
        beat_t       b;
        int          w;
        int          nbytes;
        bit          bad;
        logic [31:0] d;
        w   = (len + 3) / 4;
        bad = (len < MIN_LEN) || (len > MAX_LEN);
        e.w          = {16'($urandom()), 16'(len)};
        e.is_hdr     = 1'b1;
        e.bad        = bad;
        e.end_on_pop = bad && (w == 0);
        fifo_q.push_back(e);
        for (int i = 0; i < w; i++) begin
            d            = $urandom();
            e.w          = d;
            e.is_hdr     = 1'b0;
            e.bad        = bad;
            e.end_on_pop = bad && (i == w - 1);
            fifo_q.push_back(e);
            if (!bad) begin
                nbytes = len - 4 * (w - 1);
                b.d    = d;
                b.sof  = (i == 0);
                b.eof  = (i == w - 1);
                b.idx  = i;
                b.keep = (i == w - 1) ? 4'((1 << nbytes) - 1) : 4'hF;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic applyStimulus();
        fifo_rd_vld  = (fifo_q.size() != 0) && ($urandom_range(99) < vld_pct);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0].w : $urandom();
        m_ready      = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic checkOutput();
        fent_t e;
        beat_t b;
        bit    err_next;
        check("err_len", err_len, exp_err);
        check("frame_cnt", frame_cnt, exp_frames);
        if (held) check("hold_valid", m_valid, 1'b1);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", m_valid, 1'b0);
            end else begin
                b = exp_q[0];
                check("m_data", m_data, b.d);
                check("m_sof", m_sof, b.sof);
                check("m_eof", m_eof, b.eof);
                check("m_keep", m_keep, b.keep);
                if (m_ready) begin
                    b = exp_q.pop_front();
                    if (b.sof) sof_edge = edge_no;
                    if (b.eof) begin
                        exp_frames++;
                        last_end_edge = edge_no + 1;
                        end_valid     = 1'b1;
                        if (tput_chk) check("full_tput", edge_no - sof_edge, b.idx);
                    end
                end
            end
        end
        held     = m_valid && !m_ready;
        err_next = 1'b0;
        if (fifo_rd_en && fifo_rd_vld) begin
            e = fifo_q.pop_front();
            if (e.is_hdr) begin
                if (gap_chk && end_valid) check("ifg_gap", edge_no + 1 - last_end_edge, C_IFG + 2);
                err_next = e.bad;
            end
            if (e.end_on_pop) begin
                last_end_edge = edge_no + 1;
                end_valid     = 1'b1;
            end
        end
        @(posedge rd_clk);
        edge_no++;
        exp_err = err_next;
        @(negedge rd_clk);
    endtask

    task automatic cycle();
        applyStimulus();
        #1;
        checkOutput();
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", fifo_q.size() + exp_q.size(), 0);
        repeat (C_IFG + 4) cycle();
        end_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
        check({tag, "_valid"}, m_valid, 1'b0);
        check({tag, "_sof"}, m_sof, 1'b0);
        check({tag, "_eof"}, m_eof, 1'b0);
        check({tag, "_err"}, err_len, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_data"}, m_data, 32'h0);
        check({tag, "_keep"}, m_keep, 4'h0);
        check({tag, "_fcnt"}, frame_cnt, 16'h0);
    endtask

    initial begin
        int n;
        int len;
        rd_rst       = 1'b1;
        enable       = 1'b0;
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = 32'h0;
        m_ready      = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge rd_clk);
        @(negedge rd_clk);
        rd_rst = 1'b0;
        enable = 1'b1;

        $display("[TB] nominal frames, keep variants, inter-frame gap");
        gap_chk = 1'b1; tput_chk = 1'b1; vld_pct = 100; rdy_pct = 100;
        add_frame(64); add_frame(61); add_frame(63); add_frame(62);
        run_until_done(500);

        $display("[TB] short frame drained, then valid frame");
        add_frame(20); add_frame(64);
        run_until_done(500);

        $display("[TB] zero length, oversize drain, boundary lengths");
        add_frame(0); add_frame(1515); add_frame(60); add_frame(1514); add_frame(59);
        run_until_done(3000);

        $display("[TB] max frame with stalls and FIFO gaps");
        gap_chk = 1'b0; tput_chk = 1'b0; vld_pct = 70; rdy_pct = 50;
        add_frame(1514);
        run_until_done(5000);

        $display("[TB] enable dropped mid-frame, then held low");
        vld_pct = 100; rdy_pct = 80;
        add_frame(100);
        repeat (4) cycle();
        enable = 1'b0;
        run_until_done(500);
        add_frame(64);
        repeat (10) begin
            cycle();
            check("dis_busy", busy, 1'b0);
            check("dis_rd_en", fifo_rd_en, 1'b0);
        end
        enable = 1'b1;
        run_until_done(500);

        $display("[TB] randomized frames");
        for (int f = 0; f < 10; f++) begin
            case ($urandom_range(9))
                0:       len = $urandom_range(59);
                1:       len = $urandom_range(2000, 1515);
                default: len = $urandom_range(600, 60);
            endcase
            add_frame(len);
        end
        vld_pct = 60 + $urandom_range(40);
        rdy_pct = 40 + $urandom_range(60);
        run_until_done(20000);

        $display("[TB] reset mid-payload");
        vld_pct = 100; rdy_pct = 100;
        add_frame(64); add_frame(64);
        n = 0;
        while (exp_q.size() > 24 && n < 100) begin
            cycle();
            n++;
        end
        check("pre_reset_progress", (exp_q.size() <= 24), 1'b1);
        rd_rst = 1'b1;
        #1;
        check_all_zero("midrst");
        fifo_rd_vld = 1'b0;
        @(posedge rd_clk);
        @(posedge rd_clk);
        @(negedge rd_clk);
        fifo_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_err    = 1'b0;
        held       = 1'b0;
        end_valid  = 1'b0;
        rd_rst     = 1'b0;
        add_frame(64);
        run_until_done(500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
